// File: rtl/ssp_uart_pkg.sv
// Shared definitions for the ssp_uart SSP register interface: register map,
// access direction, frame layout and the initiator FSM state encoding.
package ssp_uart_pkg;

  localparam logic [2:0] RA_UCR = 3'd0;
  localparam logic [2:0] RA_USR = 3'd1;
  localparam logic [2:0] RA_TDR = 3'd2;
  localparam logic [2:0] RA_RDR = 3'd3;
  localparam logic [2:0] RA_SPR = 3'd4;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  typedef struct packed {
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] data;
  } ssp_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GUARD = 2'd3
  } ssp_state_t;

endpackage

// File: rtl/ssp_sck_gen.sv
// SCK timebase: emits one-cycle rise/fall enables every CLK_DIV cycles while
// enabled, alternating rise then fall; held cleared while disabled.
module ssp_sck_gen #(
  parameter int CLK_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] div_cnt;
  logic             phase;
  logic             tick;

  assign tick     = en && (div_cnt == CNT_W'(CLK_DIV - 1));
  assign sck_rise = tick && !phase;
  assign sck_fall = tick && phase;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= CNT_W'(div_cnt + 1'b1);
    end
  end

endmodule

// File: rtl/ssp_uart_spi_master.sv
// SPI mode 0 initiator: serialises one {RA, WnR, DI} request as a 16-bit frame
// and returns the low 12 bits shifted in on MISO.
module ssp_uart_spi_master
  import ssp_uart_pkg::*;
#(
  parameter int CLK_DIV = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic [2:0]  RA,
  input  logic        WnR,
  input  logic [11:0] DI,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] DO,
  output logic        SSP_SSEL,
  output logic        SSP_SCK,
  output logic        SSP_MOSI,
  input  logic        SSP_MISO,
  output ssp_state_t  dbg_state
);

  // Handshake: Req is taken on a rising Clk edge only while Busy is low;
  // Done pulses once per completed frame and DO is valid from that cycle on.

  ssp_state_t  state_q, state_d;
  ssp_frame_t  frame;
  logic [3:0]  bit_cnt;
  logic [14:0] tx_sh;
  logic [11:0] rx_sh;
  logic        sck_rise, sck_fall;
  logic        capture;

  assign frame     = '{ra: RA, wnr: WnR, data: DI};
  assign dbg_state = state_q;

  ssp_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (Clk),
    .rst      (Rst),
    .en       (state_q != ST_IDLE),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A rise tick with bit_cnt at 15 is the end of the last low phase, not a new bit.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE:  if (Req) state_d = ST_SETUP;
      ST_SETUP: begin
        capture = sck_rise;
        if (sck_rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        capture = sck_rise && (bit_cnt != 4'd15);
        if (sck_rise && bit_cnt == 4'd15) state_d = ST_GUARD;
      end
      ST_GUARD: if (sck_fall) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Busy     <= 1'b0;
      Done     <= 1'b0;
      DO       <= '0;
      SSP_SSEL <= 1'b0;
      SSP_SCK  <= 1'b0;
      SSP_MOSI <= 1'b0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        ST_IDLE: if (Req) begin
          Busy     <= 1'b1;
          SSP_SSEL <= 1'b1;
          SSP_SCK  <= 1'b0;
          SSP_MOSI <= frame[15];
          tx_sh    <= frame[14:0];
          rx_sh    <= '0;
          bit_cnt  <= '0;
        end
        ST_SETUP, ST_SHIFT: begin
          if (capture) begin
            SSP_SCK <= 1'b1;
            rx_sh   <= {rx_sh[10:0], SSP_MISO};
            if (state_q == ST_SHIFT) bit_cnt <= bit_cnt + 4'd1;
          end
          if (sck_fall) begin
            SSP_SCK <= 1'b0;
            if (bit_cnt != 4'd15) begin
              SSP_MOSI <= tx_sh[14];
              tx_sh    <= {tx_sh[13:0], 1'b0};
            end
          end
          if (state_d == ST_GUARD) begin
            SSP_SSEL <= 1'b0;
            Done     <= 1'b1;
            DO       <= rx_sh;
          end
        end
        ST_GUARD: if (sck_fall) Busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssp_uart_spi_master.sv
// Directed bench for ssp_uart_spi_master with a mode-0 SSP slave model,
// plus a CLK_DIV=1 instance for the fast-clock frame.
module tb_ssp_uart_spi_master;
  import ssp_uart_pkg::*;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // DUT (CLK_DIV=3)
  logic        Req = 1'b0, WnR = 1'b0;
  logic [2:0]  RA = 3'd0;
  logic [11:0] DI = 12'd0;
  logic        Busy, Done, SSP_SSEL, SSP_SCK, SSP_MOSI, SSP_MISO;
  logic [11:0] DO;
  ssp_state_t  dbg_state;

  ssp_uart_spi_master #(.CLK_DIV(3)) u_dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .RA(RA), .WnR(WnR), .DI(DI),
    .Busy(Busy), .Done(Done), .DO(DO), .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK),
    .SSP_MOSI(SSP_MOSI), .SSP_MISO(SSP_MISO), .dbg_state(dbg_state)
  );

  // DUT (CLK_DIV=1)
  logic        Req_1 = 1'b0, WnR_1 = 1'b0;
  logic [2:0]  RA_1 = 3'd0;
  logic [11:0] DI_1 = 12'd0;
  logic        Busy_1, Done_1, SSEL_1, SCK_1, MOSI_1;
  logic [11:0] DO_1;
  ssp_state_t  dbg_state_1;

  ssp_uart_spi_master #(.CLK_DIV(1)) u_dut_1 (
    .Clk(Clk), .Rst(Rst), .Req(Req_1), .RA(RA_1), .WnR(WnR_1), .DI(DI_1),
    .Busy(Busy_1), .Done(Done_1), .DO(DO_1), .SSP_SSEL(SSEL_1), .SSP_SCK(SCK_1),
    .SSP_MOSI(MOSI_1), .SSP_MISO(1'b0), .dbg_state(dbg_state_1)
  );

  // scoreboard counters
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // mode-0 slave model: loads miso_word on SSEL rise, shifts on SCK fall
  logic [15:0] miso_word = 16'h0000;
  logic [15:0] slv_sh = 16'h0000;
  logic [15:0] mosi_word = 16'h0000;
  logic [11:0] slv_regs [8];
  logic        p_ssel = 1'b0, p_sck = 1'b0;
  int          rise_cnt = 0, ssel_rises = 0, sck_outside = 0;
  time         ssel_fall_t = 0, ssel_gap = 0;

  assign SSP_MISO = slv_sh[15];

  always @(SSP_SSEL or SSP_SCK) begin
    if (SSP_SSEL === 1'b1 && p_ssel !== 1'b1) begin
      slv_sh    = miso_word;
      mosi_word = 16'h0000;
      rise_cnt  = 0;
      ssel_rises++;
      ssel_gap  = $time - ssel_fall_t;
    end
    if (SSP_SSEL === 1'b0 && p_ssel === 1'b1) begin
      ssel_fall_t = $time;
      if (rise_cnt == 16 && mosi_word[12]) slv_regs[mosi_word[15:13]] = mosi_word[11:0];
    end
    if (SSP_SCK === 1'b1 && p_sck !== 1'b1) begin
      mosi_word = {mosi_word[14:0], SSP_MOSI};
      rise_cnt++;
      if (SSP_SSEL !== 1'b1) sck_outside++;
    end
    if (SSP_SCK === 1'b0 && p_sck === 1'b1 && SSP_SSEL === 1'b1)
      slv_sh = {slv_sh[14:0], 1'b0};
    p_ssel = SSP_SSEL;
    p_sck  = SSP_SCK;
  end

  int done_cnt = 0;
  always @(negedge Clk) if (Done === 1'b1) done_cnt++;

  // capture for the CLK_DIV=1 instance
  logic [15:0] mosi_1 = 16'h0000;
  time         last_rise_1 = 0, sck_per_1 = 0;
  always @(posedge SCK_1) begin
    mosi_1 = {mosi_1[14:0], MOSI_1};
    if (last_rise_1 != 0) sck_per_1 = $time - last_rise_1;
    last_rise_1 = $time;
  end

  // driver tasks
  int req_cyc = 0;

  task automatic start_req(input logic [2:0] ra, input logic wnr, input logic [11:0] di);
    @(negedge Clk);
    RA = ra; WnR = wnr; DI = di; Req = 1'b1;
    req_cyc = cyc;
    @(negedge Clk);
    Req = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      @(negedge Clk);
      if (Done === 1'b1) lat = cyc - req_cyc;
    end
  endtask

  task automatic wait_idle(output int lat);
    lat = -1;
    for (int i = 0; i < 300 && lat < 0; i++) begin
      if (Busy === 1'b0) lat = cyc - req_cyc;
      else @(negedge Clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  int lat, d0, s0;

  initial begin
    for (int i = 0; i < 8; i++) slv_regs[i] = 12'h000;
    repeat (4) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // reset state
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_do", DO, 12'h000);
    chk("rst_ssel", SSP_SSEL, 1'b0);
    chk("rst_sck", SSP_SCK, 1'b0);
    chk("rst_mosi", SSP_MOSI, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);

    // write UCR 5A3; slave status nibble must be dropped from DO
    miso_word = 16'hF7E5;
    start_req(RA_UCR, WRITE, 12'h5A3);
    chk("wr_busy_accept", Busy, 1'b1);
    chk("wr_ssel_accept", SSP_SSEL, 1'b1);
    chk("wr_mosi_msb", SSP_MOSI, 1'b0);
    wait_done(lat);
    chk("wr_done_lat", lat, 100);
    chk("wr_mosi_frame", mosi_word, 16'h15A3);
    chk("wr_sck_pulses", rise_cnt, 16);
    chk("wr_sck_outside_ssel", sck_outside, 0);
    chk("wr_do", DO, 12'h7E5);
    chk("wr_ssel_at_done", SSP_SSEL, 1'b0);
    @(negedge Clk);
    chk("wr_done_one_cycle", Done, 1'b0);
    wait_idle(lat);
    chk("wr_busy_lat", lat, 103);

    // read USR
    miso_word = 16'h00C3;
    start_req(RA_USR, READ, 12'h000);
    wait_done(lat);
    chk("rd_usr_lat", lat, 100);
    chk("rd_usr_mosi", mosi_word, 16'h2000);
    chk("rd_usr_do", DO, 12'h0C3);
    wait_idle(lat);

    // read RDR
    miso_word = 16'hF0FF;
    start_req(RA_RDR, READ, 12'h000);
    wait_done(lat);
    chk("rd_rdr_mosi", mosi_word, 16'h6000);
    chk("rd_rdr_do", DO, 12'h0FF);
    wait_idle(lat);

    // write SPR then read it back with Req held high; inputs change mid-frame
    miso_word = 16'h0000;
    @(negedge Clk);
    RA = RA_SPR; WnR = WRITE; DI = 12'hABC; Req = 1'b1;
    req_cyc = cyc;
    @(negedge Clk);
    WnR = READ; DI = 12'h123;
    wait_done(lat);
    chk("spr_wr_lat", lat, 100);
    chk("spr_wr_mosi", mosi_word, 16'h9ABC);
    miso_word = {4'h0, slv_regs[RA_SPR]};
    wait_idle(lat);
    chk("spr_busy_lat", lat, 103);
    @(negedge Clk);
    Req = 1'b0;
    chk("b2b_accept", Busy, 1'b1);
    req_cyc = cyc - 1;
    wait_done(lat);
    chk("spr_rd_lat", lat, 100);
    chk("spr_rd_mosi", mosi_word, 16'h8123);
    chk("spr_rd_do", DO, 12'hABC);
    chk("ssel_gap", 32'(ssel_gap), 40);
    wait_idle(lat);

    // Req pulses while Busy are ignored
    d0 = done_cnt; s0 = ssel_rises;
    miso_word = 16'h0000;
    start_req(RA_TDR, WRITE, 12'h3C3);
    for (int i = 0; i < 130; i++) begin
      @(negedge Clk);
      Req = (cyc == req_cyc + 20) || (cyc == req_cyc + 99);
      if (cyc == req_cyc + 99) chk("ign_busy_at_99", Busy, 1'b1);
    end
    Req = 1'b0;
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_frame_count", ssel_rises - s0, 1);
    chk("ign_idle", Busy, 1'b0);

    // reset during bit 7 aborts the frame
    start_req(RA_UCR, WRITE, 12'hFFF);
    for (int i = 0; i < 200 && rise_cnt != 8; i++) @(negedge Clk);
    chk("abort_bit7_reached", rise_cnt, 8);
    d0 = done_cnt;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_ssel", SSP_SSEL, 1'b0);
    chk("abort_sck", SSP_SCK, 1'b0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_do", DO, 12'h000);
    repeat (120) @(negedge Clk);
    chk("abort_no_done", done_cnt - d0, 0);

    start_req(RA_UCR, WRITE, 12'h001);
    wait_done(lat);
    chk("post_abort_lat", lat, 100);
    chk("post_abort_mosi", mosi_word, 16'h1001);
    wait_idle(lat);
    chk("post_abort_busy_lat", lat, 103);

    // CLK_DIV=1 instance
    @(negedge Clk);
    RA_1 = RA_TDR; WnR_1 = WRITE; DI_1 = 12'h041; Req_1 = 1'b1;
    req_cyc = cyc;
    @(negedge Clk);
    Req_1 = 1'b0;
    lat = -1;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge Clk);
      if (Done_1 === 1'b1) lat = cyc - req_cyc;
    end
    chk("div1_done_lat", lat, 34);
    chk("div1_mosi", mosi_1, 16'h5041);
    chk("div1_sck_period", 32'(sck_per_1), 20);
    repeat (4) @(negedge Clk);
    chk("div1_idle", Busy_1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
